// File: rtl/neo_pkg.sv
// +--------------------------------------------------------------------------+
// | neo_pkg : shared types and constants for the NeoPixel pattern producer   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package neo_pkg;

  typedef enum logic [1:0] {
    MODE_SOLID = 2'd0,
    MODE_CHASE = 2'd1,
    MODE_RAMP  = 2'd2,
    MODE_OFF   = 2'd3
  } mode_t;

  localparam logic [1:0] COLOR_G = 2'd0;
  localparam logic [1:0] COLOR_R = 2'd1;
  localparam logic [1:0] COLOR_B = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_SEND = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/neo_counter.sv
// +--------------------------------------------------------------------------+
// | neo_counter : wrapping up-counter with synchronous clear (0..MAX)        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module neo_counter #(
  parameter int          WIDTH = 8,
  parameter int unsigned MAX   = 255
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/neo_level_gen.sv
// +--------------------------------------------------------------------------+
// | neo_level_gen : combinational level for (mode, base, phase, pixel, color)|
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module neo_level_gen
  import neo_pkg::*;
#(
  parameter int PIX_W   = 3,
  parameter int LEVEL_W = 8,
  parameter int STEP    = 8
) (
  input  logic [1:0]         mode_i,
  input  logic [LEVEL_W-1:0] base_i,
  input  logic [PIX_W-1:0]   chase_phase_i,
  input  logic [LEVEL_W-1:0] ramp_phase_i,
  input  logic [PIX_W-1:0]   pixel_i,
  input  logic [1:0]         color_i,
  output logic [LEVEL_W-1:0] level_o
);

  localparam logic [LEVEL_W-1:0] STEP_L = LEVEL_W'(STEP);

  logic [LEVEL_W-1:0] ramp;

  always_comb begin
    ramp    = base_i + LEVEL_W'(pixel_i) * STEP_L + ramp_phase_i;
    level_o = '0;
    case (mode_t'(mode_i))
      MODE_SOLID: level_o = base_i;
      MODE_CHASE: begin
        if (pixel_i == chase_phase_i) begin
          level_o = base_i;
        end
      end
      MODE_RAMP: begin
        case (color_i)
          COLOR_G: level_o = ramp;
          COLOR_R: level_o = ~ramp;
          COLOR_B: level_o = ramp >> 1;
          default: level_o = '0;
        endcase
      end
      default: level_o = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/neo_pattern_producer.sv
// +--------------------------------------------------------------------------+
// | neo_pattern_producer : frame producer for the NeoPixel driver            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module neo_pattern_producer
  import neo_pkg::*;
#(
  parameter int NUM_PIXELS = 5,
  parameter int PIX_W      = 3,
  parameter int LEVEL_W    = 8,
  parameter int REPEAT_W   = 16,
  parameter int STEP       = 8
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                enable_i,
  input  logic [1:0]          mode_i,
  input  logic [LEVEL_W-1:0]  base_level_i,
  input  logic [REPEAT_W-1:0] frame_repeat_i,
  input  logic                ready_to_load_i,
  input  logic                ready_to_send_i,
  input  logic                done_wait_i,
  output logic [PIX_W-1:0]    pixel_index_o,
  output logic [1:0]          color_index_o,
  output logic [LEVEL_W-1:0]  color_level_o,
  output logic                load_color_o,
  output logic                send_it_o,
  output logic [15:0]         frame_count_o,
  output logic                busy_o
);

  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIXELS - 1);

  state_t                state_q, state_d;
  mode_t                 mode_q;
  logic [LEVEL_W-1:0]    base_q;
  logic [REPEAT_W-1:0]   frame_rep_q;

  logic                  load, send, latch, idx_clr, idx_inc;
  logic                  rep_inc, rep_clr, phase_adv;
  logic [1:0]            color_cnt;
  logic [PIX_W-1:0]      pixel_cnt;
  logic [REPEAT_W-1:0]   rep_cnt, rep_lim;
  logic [PIX_W-1:0]      chase_phase;
  logic [LEVEL_W-1:0]    ramp_phase;
  logic [LEVEL_W-1:0]    level;

  assign rep_lim = (frame_rep_q == '0) ? REPEAT_W'(1) : frame_rep_q;

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    send      = 1'b0;
    latch     = 1'b0;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    rep_inc   = 1'b0;
    rep_clr   = 1'b0;
    phase_adv = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          latch   = 1'b1;
          idx_clr = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (ready_to_load_i) begin
          load    = 1'b1;
          idx_inc = 1'b1;
          if (pixel_cnt == LAST_PIX && color_cnt == COLOR_B) begin
            state_d = ST_WAIT_SEND;
          end
        end
      end
      ST_WAIT_SEND: begin
        if (ready_to_send_i) begin
          send    = 1'b1;
          rep_inc = 1'b1;
          state_d = ST_WAIT_DONE;
        end
      end
      default: begin
        if (done_wait_i) begin
          if (!enable_i) begin
            idx_clr = 1'b1;
            state_d = ST_IDLE;
          end else if (rep_cnt < rep_lim) begin
            state_d = ST_WAIT_SEND;
          end else begin
            rep_clr   = 1'b1;
            phase_adv = 1'b1;
            latch     = 1'b1;
            idx_clr   = 1'b1;
            state_d   = ST_LOAD;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_SOLID;
      base_q      <= '0;
      frame_rep_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch) begin
        mode_q      <= mode_t'(mode_i);
        base_q      <= base_level_i;
        frame_rep_q <= frame_repeat_i;
      end
    end
  end

  neo_counter #(.WIDTH(2), .MAX(2)) u_color (
    .clock_i (clock_i), .reset_i (reset_i), .clear_i (idx_clr),
    .inc_i   (idx_inc), .count_o (color_cnt)
  );

  neo_counter #(.WIDTH(PIX_W), .MAX(NUM_PIXELS - 1)) u_pixel (
    .clock_i (clock_i), .reset_i (reset_i), .clear_i (idx_clr),
    .inc_i   (idx_inc && color_cnt == COLOR_B), .count_o (pixel_cnt)
  );

  neo_counter #(.WIDTH(REPEAT_W), .MAX(2**REPEAT_W - 1)) u_repeat (
    .clock_i (clock_i), .reset_i (reset_i), .clear_i (rep_clr),
    .inc_i   (rep_inc), .count_o (rep_cnt)
  );

  neo_counter #(.WIDTH(16), .MAX(65535)) u_frame (
    .clock_i (clock_i), .reset_i (reset_i), .clear_i (1'b0),
    .inc_i   (send), .count_o (frame_count_o)
  );

  // Phase is held once per modulus so CHASE and RAMP each see their own wrap.
  neo_counter #(.WIDTH(PIX_W), .MAX(NUM_PIXELS - 1)) u_chase_phase (
    .clock_i (clock_i), .reset_i (reset_i), .clear_i (1'b0),
    .inc_i   (phase_adv), .count_o (chase_phase)
  );

  neo_counter #(.WIDTH(LEVEL_W), .MAX(2**LEVEL_W - 1)) u_ramp_phase (
    .clock_i (clock_i), .reset_i (reset_i), .clear_i (1'b0),
    .inc_i   (phase_adv), .count_o (ramp_phase)
  );

  neo_level_gen #(.PIX_W(PIX_W), .LEVEL_W(LEVEL_W), .STEP(STEP)) u_level (
    .mode_i        (mode_q),
    .base_i        (base_q),
    .chase_phase_i (chase_phase),
    .ramp_phase_i  (ramp_phase),
    .pixel_i       (pixel_cnt),
    .color_i       (color_cnt),
    .level_o       (level)
  );

  assign load_color_o  = load;
  assign send_it_o     = send;
  assign pixel_index_o = load ? pixel_cnt : '0;
  assign color_index_o = load ? color_cnt : 2'd0;
  assign color_level_o = load ? level : '0;
  assign busy_o        = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_neo_pattern_producer.sv
// +--------------------------------------------------------------------------+
// | tb_neo_pattern_producer : self-checking bench for neo_pattern_producer   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_neo_pattern_producer;

  localparam int N = 5;

  logic        clk, rst, en;
  logic [1:0]  mode;
  logic [7:0]  base;
  logic [15:0] fr;
  logic        rtl, rts, dw;
  logic [2:0]  pix;
  logic [1:0]  col;
  logic [7:0]  lvl;
  logic        ld_o, snd_o, busy;
  logic [15:0] fcnt;

  neo_pattern_producer dut (
    .clock_i         (clk),
    .reset_i         (rst),
    .enable_i        (en),
    .mode_i          (mode),
    .base_level_i    (base),
    .frame_repeat_i  (fr),
    .ready_to_load_i (rtl),
    .ready_to_send_i (rts),
    .done_wait_i     (dw),
    .pixel_index_o   (pix),
    .color_index_o   (col),
    .color_level_o   (lvl),
    .load_color_o    (ld_o),
    .send_it_o       (snd_o),
    .frame_count_o   (fcnt),
    .busy_o          (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int chk = 0;
  int err = 0;

  task automatic check(input string name, input int act, input int exp);
    chk++;
    if (act != exp) begin
      err++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: stage 0 idle, 1 loading, 2 awaiting send slot, 3 awaiting done.
  int st, nld, k, rep, fc, m_mode, m_base, m_rep;

  function automatic int exp_level(input int p, input int c);
    int l;
    case (m_mode)
      0: return m_base;
      1: return (p == (k % N)) ? m_base : 0;
      2: begin
        l = (m_base + p * 8 + (k % 256)) % 256;
        if (c == 0) return l;
        if (c == 1) return 255 - l;
        return l / 2;
      end
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      st = 0; nld = 0; k = 0; rep = 0; fc = 0; m_mode = 0; m_base = 0; m_rep = 0;
    end else begin
      case (st)
        0: if (en) begin
          m_mode = int'(mode); m_base = int'(base); m_rep = int'(fr); nld = 0; st = 1;
        end
        1: if (rtl) begin
          nld++;
          if (nld == 3 * N) begin nld = 0; st = 2; end
        end
        2: if (rts) begin
          fc = (fc + 1) % 65536; rep = (rep + 1) % 65536; st = 3;
        end
        default: if (dw) begin
          if (!en) st = 0;
          else if (rep < ((m_rep == 0) ? 1 : m_rep)) st = 2;
          else begin
            rep = 0; k++;
            m_mode = int'(mode); m_base = int'(base); m_rep = int'(fr); nld = 0; st = 1;
          end
        end
      endcase
    end
  end

  int log_p[256], log_c[256], log_l[256], log_cyc[256], send_nlog[64];
  int nlog = 0, nsend = 0, cyc = 0;

  always @(negedge clk) begin
    bit e_ld;
    cyc++;
    e_ld = (st == 1) && rtl;
    check("load_color", int'(ld_o), int'(e_ld));
    check("send_it", int'(snd_o), int'((st == 2) && rts));
    check("busy", int'(busy), int'(st != 0));
    check("frame_count", int'(fcnt), fc);
    check("pixel_index", int'(pix), e_ld ? nld / 3 : 0);
    check("color_index", int'(col), e_ld ? nld % 3 : 0);
    check("color_level", int'(lvl), e_ld ? exp_level(nld / 3, nld % 3) : 0);
    if (rst) begin
      nlog = 0; nsend = 0;
    end else begin
      if (ld_o && nlog < 256) begin
        log_p[nlog] = int'(pix); log_c[nlog] = int'(col);
        log_l[nlog] = int'(lvl); log_cyc[nlog] = cyc; nlog++;
      end
      if (snd_o) begin
        if (nsend < 64) send_nlog[nsend] = nlog;
        nsend++;
      end
    end
  end

  // Handshake driver: 0 manual, 1 toggle ready_to_load, 2 random.
  int pol = 0;
  logic man_rtl = 1'b0, man_rts = 1'b0, man_dw = 1'b0;

  always @(posedge clk) begin
    #1;
    case (pol)
      0: begin rtl = man_rtl; rts = man_rts; dw = man_dw; end
      1: begin rtl = !rtl; rts = man_rts; dw = man_dw; end
      default: begin
        rtl = 1'($urandom_range(0, 1));
        rts = 1'($urandom_range(0, 1));
        dw  = ($urandom_range(0, 3) == 0);
      end
    endcase
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic do_reset();
    en = 1'b0; pol = 0; man_rtl = 1'b1; man_rts = 1'b1; man_dw = 1'b0;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic wait_sends(input int n, input string name);
    int t = 0;
    while (nsend < n && t < 500) begin tick(1); t++; end
    check(name, int'(nsend >= n), 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; mode = 2'd0; base = 8'h00; fr = 16'd1;
    rtl = 1'b0; rts = 1'b0; dw = 1'b0;
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_load", int'(ld_o), 0);
    check("reset_frame_count", int'(fcnt), 0);

    // 1: SOLID base 0x20, back-to-back loads
    do_reset();
    mode = 2'd0; base = 8'h20; fr = 16'd1; en = 1'b1;
    wait_sends(1, "t1_send_timeout");
    check("t1_nloads", nlog, 15);
    check("t1_consecutive", log_cyc[14] - log_cyc[0], 14);
    check("t1_first_pix", log_p[0], 0);
    check("t1_first_col", log_c[0], 0);
    check("t1_mid_pix", log_p[4], 1);
    check("t1_mid_col", log_c[4], 1);
    check("t1_last_pix", log_p[14], 4);
    check("t1_last_col", log_c[14], 2);
    check("t1_level", log_l[9], 8'h20);
    check("t1_frame_count", int'(fcnt), 1);

    // 2: CHASE base 0xFF, two sends per frame, phase walks the strip
    do_reset();
    mode = 2'd1; base = 8'hFF; fr = 16'd2; man_dw = 1'b1; en = 1'b1;
    wait_sends(12, "t2_send_timeout");
    en = 1'b0;
    check("t2_first_send_at", send_nlog[0], 15);
    check("t2_no_reload_between", send_nlog[1], 15);
    check("t2_third_send_at", send_nlog[2], 30);
    check("t2_f0_pix0_lit", log_l[0], 8'hFF);
    check("t2_f0_pix1_dark", log_l[3], 0);
    check("t2_f1_pix0_dark", log_l[15], 0);
    check("t2_f1_pix1_lit", log_l[18], 8'hFF);
    check("t2_f5_pix0_lit", log_l[75], 8'hFF);
    check("t2_f5_pix4_dark", log_l[87], 0);

    // 3: ready_to_load toggling
    do_reset();
    mode = 2'd2; base = 8'h11; fr = 16'd1; pol = 1; en = 1'b1;
    wait_sends(1, "t3_send_timeout");
    check("t3_nloads", nlog, 15);
    begin
      int bad = 0;
      for (int i = 0; i < 15; i++)
        if (log_p[i] != i / 3 || log_c[i] != i % 3) bad++;
      check("t3_order", bad, 0);
    end

    // 4: RAMP wraparound at base 0xF8
    do_reset();
    mode = 2'd2; base = 8'hF8; fr = 16'd1; en = 1'b1;
    wait_sends(1, "t4_send_timeout");
    check("t4_p1_g", log_l[3], 8'h00);
    check("t4_p1_r", log_l[4], 8'hFF);
    check("t4_p1_b", log_l[5], 8'h00);
    check("t4_p2_g", log_l[6], 8'h08);
    check("t4_p0_b", log_l[2], 8'h7C);

    // 5: reset during LOAD at pixel 2
    do_reset();
    mode = 2'd0; base = 8'h40; fr = 16'd1; en = 1'b1;
    begin
      int t = 0;
      while (!(ld_o && pix == 3'd2) && t < 100) begin tick(1); t++; end
      check("t5_reached_pix2", int'(ld_o && pix == 3'd2), 1);
    end
    rst = 1'b1;
    #1;
    check("t5_load_in_reset", int'(ld_o), 0);
    check("t5_pix_in_reset", int'(pix), 0);
    check("t5_level_in_reset", int'(lvl), 0);
    check("t5_busy_in_reset", int'(busy), 0);
    tick(1);
    rst = 1'b0;
    wait_sends(1, "t5_send_timeout");
    check("t5_restart_pix", log_p[0], 0);
    check("t5_restart_col", log_c[0], 0);
    check("t5_restart_nloads", nlog, 15);

    // 6: enable dropped in WAIT_DONE with frame_repeat 0
    do_reset();
    mode = 2'd3; base = 8'h55; fr = 16'd0; en = 1'b1;
    wait_sends(1, "t6_send_timeout");
    en = 1'b0;
    tick(3);
    check("t6_busy_waiting", int'(busy), 1);
    check("t6_single_send", nsend, 1);
    man_dw = 1'b1;
    tick(2);
    check("t6_idle_busy", int'(busy), 0);
    check("t6_sends_after", nsend, 1);
    check("t6_frame_count", int'(fcnt), 1);

    // Randomized run against the reference
    do_reset();
    pol = 2; en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        mode = 2'($urandom_range(0, 3));
        base = 8'($urandom_range(0, 255));
        fr   = 16'($urandom_range(0, 3));
      end
      en = ($urandom_range(0, 19) != 0);
      tick(1);
    end

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

`default_nettype wire
